// File: rtl/xbee_pkg.sv
// Shared types and constants for the XBee UART link.
// Build option: XBEE_UART_PARITY_EN adds an even-parity bit to every frame.
package xbee_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } xbee_state_e;

`ifdef XBEE_UART_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int FRAME_BITS         = 1 + DEFAULT_DATA_WIDTH + PARITY_BITS + 1;

    function automatic int clks_per_bit(input int clkfreq, input int baud);
        return clkfreq / baud;
    endfunction

    // Narrower characters are zero-extended, which leaves even parity unchanged.
    function automatic logic even_parity(input logic [8:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/xbee_uart_fifo_sync_fifo.sv
// First-word-fall-through synchronous FIFO with an occupancy count.
// A push into a full FIFO succeeds when a pop frees the slot in the same cycle.
module xbee_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_wr;
    logic             w_rd;

    assign o_full     = (r_level == (AW+1)'(DEPTH));
    assign o_empty    = (r_level == '0);
    assign w_rd       = i_pop & ~o_empty;
    assign w_wr       = i_push & (~o_full | w_rd);
    assign o_level    = r_level;
    assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1'b1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1'b1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (AW+1)'(1'b1);
                2'b01:   r_level <= r_level - (AW+1)'(1'b1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/xbee_uart_fifo.sv
// Full-duplex FIFO-buffered UART with valid/ready streaming on both sides.
// Build option: XBEE_UART_PARITY_EN inserts an even-parity bit before stop.
module xbee_uart_fifo
    import xbee_pkg::*;
#(
    parameter int CLKFREQ    = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int TX_DEPTH   = 16,
    parameter int RX_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic [DATA_WIDTH-1:0]       rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic                        txd,
    input  logic                        rxd,
    output logic                        rx_overrun,
    output logic                        rx_frame_err,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic [$clog2(RX_DEPTH):0]   rx_level
);

    localparam int CPB   = clks_per_bit(CLKFREQ, BAUD);
    localparam int CNT_W = $clog2(CPB);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    logic                  w_tx_full, w_tx_empty, w_tx_push, w_tx_pop, w_tx_load;
    logic [DATA_WIDTH-1:0] w_tx_head;
    xbee_state_e           r_tx_state, w_tx_state_nx;
    logic [CNT_W-1:0]      r_tx_cnt, w_tx_cnt_nx;
    logic [BIT_W-1:0]      r_tx_bit, w_tx_bit_nx;
    logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_shift_nx;
    logic                  r_txd, w_txd_nx;

    logic                  w_rx_full, w_rx_empty, w_rx_fall, w_rx_good;
    logic                  r_rxd_meta, r_rxd_sync, r_rxd_prev;
    xbee_state_e           r_rx_state, w_rx_state_nx;
    logic [CNT_W-1:0]      r_rx_cnt, w_rx_cnt_nx;
    logic [BIT_W-1:0]      r_rx_bit, w_rx_bit_nx;
    logic [DATA_WIDTH-1:0] r_rx_shift, w_rx_shift_nx;
    logic                  r_rx_brk, w_rx_brk_nx;
    logic                  r_rx_push, w_rx_push_nx;
    logic                  r_rx_frame_err, w_rx_ferr_nx;
    logic                  r_rx_overrun;

`ifdef XBEE_UART_PARITY_EN
    logic r_tx_par, w_tx_par_nx;
    logic r_rx_par, w_rx_par_nx;
    assign w_rx_good = r_rxd_sync & (r_rx_par == even_parity(9'(r_rx_shift)));
`else
    assign w_rx_good = r_rxd_sync;
`endif

    assign tx_ready     = ~w_tx_full;
    assign w_tx_push    = tx_valid & ~w_tx_full;
    assign txd          = r_txd;
    assign rx_valid     = ~w_rx_empty;
    assign rx_overrun   = r_rx_overrun;
    assign rx_frame_err = r_rx_frame_err;
    assign w_rx_fall    = r_rxd_prev & ~r_rxd_sync;

    xbee_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset),
        .i_push(w_tx_push), .i_push_data(tx_data),
        .i_pop(w_tx_pop), .o_pop_data(w_tx_head),
        .o_full(w_tx_full), .o_empty(w_tx_empty), .o_level(tx_level)
    );

    xbee_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset),
        .i_push(r_rx_push), .i_push_data(r_rx_shift),
        .i_pop(rx_ready), .o_pop_data(rx_data),
        .o_full(w_rx_full), .o_empty(w_rx_empty), .o_level(rx_level)
    );

    // TX next state: txd is computed one cycle ahead so the line is a flop.
    always_comb begin
        w_tx_state_nx = r_tx_state;
        w_tx_cnt_nx   = r_tx_cnt + CNT_W'(1'b1);
        w_tx_bit_nx   = r_tx_bit;
        w_tx_shift_nx = r_tx_shift;
        w_txd_nx      = r_txd;
        w_tx_load     = 1'b0;
        w_tx_pop      = 1'b0;
`ifdef XBEE_UART_PARITY_EN
        w_tx_par_nx   = r_tx_par;
`endif
        case (r_tx_state)
            ST_IDLE: begin
                w_tx_cnt_nx = '0;
                w_txd_nx    = 1'b1;
                w_tx_load   = ~w_tx_empty;
            end
            ST_START: begin
                if (r_tx_cnt == CNT_LAST) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = ST_DATA;
                    w_txd_nx      = r_tx_shift[0];
                end else begin
                    w_txd_nx = 1'b0;
                end
            end
            ST_DATA: begin
                if (r_tx_cnt == CNT_LAST) begin
                    w_tx_cnt_nx = '0;
                    if (r_tx_bit == BIT_LAST) begin
`ifdef XBEE_UART_PARITY_EN
                        w_tx_state_nx = ST_PARITY;
                        w_txd_nx      = r_tx_par;
`else
                        w_tx_state_nx = ST_STOP;
                        w_txd_nx      = 1'b1;
`endif
                    end else begin
                        w_tx_bit_nx   = r_tx_bit + BIT_W'(1'b1);
                        w_tx_shift_nx = r_tx_shift >> 1;
                        w_txd_nx      = r_tx_shift[1];
                    end
                end else begin
                    w_txd_nx = r_tx_shift[0];
                end
            end
            ST_PARITY: begin
                if (r_tx_cnt == CNT_LAST) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = ST_STOP;
                    w_txd_nx      = 1'b1;
                end else begin
                    w_txd_nx = r_txd;
                end
            end
            ST_STOP: begin
                w_txd_nx = 1'b1;
                if (r_tx_cnt == CNT_LAST) begin
                    w_tx_cnt_nx   = '0;
                    w_tx_state_nx = ST_IDLE;
                    w_tx_load     = ~w_tx_empty;
                end else begin
                    w_tx_load = 1'b0;
                end
            end
            default: begin
                w_tx_state_nx = ST_IDLE;
                w_tx_cnt_nx   = '0;
                w_txd_nx      = 1'b1;
            end
        endcase
        // Loading straight from STOP keeps queued frames back-to-back.
        if (w_tx_load) begin
            w_tx_pop      = 1'b1;
            w_tx_shift_nx = w_tx_head;
            w_tx_bit_nx   = '0;
            w_tx_cnt_nx   = '0;
            w_tx_state_nx = ST_START;
            w_txd_nx      = 1'b0;
`ifdef XBEE_UART_PARITY_EN
            w_tx_par_nx   = even_parity(9'(w_tx_head));
`endif
        end else begin
            w_tx_pop = 1'b0;
        end
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= ST_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nx;
            r_tx_cnt   <= w_tx_cnt_nx;
            r_tx_bit   <= w_tx_bit_nx;
            r_tx_shift <= w_tx_shift_nx;
            r_txd      <= w_txd_nx;
        end
    end

    // rxd synchronizer plus one extra stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
            r_rxd_prev <= r_rxd_sync;
        end
    end

    // RX next state: after a bad stop bit, hold in STOP until the line is high.
    always_comb begin
        w_rx_state_nx = r_rx_state;
        w_rx_cnt_nx   = r_rx_cnt + CNT_W'(1'b1);
        w_rx_bit_nx   = r_rx_bit;
        w_rx_shift_nx = r_rx_shift;
        w_rx_brk_nx   = r_rx_brk;
        w_rx_push_nx  = 1'b0;
        w_rx_ferr_nx  = 1'b0;
`ifdef XBEE_UART_PARITY_EN
        w_rx_par_nx   = r_rx_par;
`endif
        case (r_rx_state)
            ST_IDLE: begin
                w_rx_cnt_nx = '0;
                if (w_rx_fall) begin
                    w_rx_state_nx = ST_START;
                end else begin
                    w_rx_state_nx = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_rx_cnt == CNT_HALF) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_bit_nx   = '0;
                    w_rx_state_nx = r_rxd_sync ? ST_IDLE : ST_DATA;
                end else begin
                    w_rx_state_nx = ST_START;
                end
            end
            ST_DATA: begin
                if (r_rx_cnt == CNT_LAST) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_shift_nx = {r_rxd_sync, r_rx_shift[DATA_WIDTH-1:1]};
                    if (r_rx_bit == BIT_LAST) begin
`ifdef XBEE_UART_PARITY_EN
                        w_rx_state_nx = ST_PARITY;
`else
                        w_rx_state_nx = ST_STOP;
`endif
                    end else begin
                        w_rx_bit_nx = r_rx_bit + BIT_W'(1'b1);
                    end
                end else begin
                    w_rx_state_nx = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (r_rx_cnt == CNT_LAST) begin
                    w_rx_cnt_nx   = '0;
                    w_rx_state_nx = ST_STOP;
`ifdef XBEE_UART_PARITY_EN
                    w_rx_par_nx   = r_rxd_sync;
`endif
                end else begin
                    w_rx_state_nx = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (r_rx_brk) begin
                    w_rx_cnt_nx = '0;
                    if (r_rxd_sync) begin
                        w_rx_brk_nx   = 1'b0;
                        w_rx_state_nx = ST_IDLE;
                    end else begin
                        w_rx_state_nx = ST_STOP;
                    end
                end else if (r_rx_cnt == CNT_LAST) begin
                    w_rx_cnt_nx = '0;
                    if (w_rx_good) begin
                        w_rx_push_nx  = 1'b1;
                        w_rx_state_nx = ST_IDLE;
                    end else begin
                        w_rx_ferr_nx = 1'b1;
                        w_rx_brk_nx  = 1'b1;
                    end
                end else begin
                    w_rx_state_nx = ST_STOP;
                end
            end
            default: begin
                w_rx_state_nx = ST_IDLE;
                w_rx_cnt_nx   = '0;
                w_rx_brk_nx   = 1'b0;
            end
        endcase
    end

    // RX state register and status pulses; the FIFO decides on overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state     <= ST_IDLE;
            r_rx_cnt       <= '0;
            r_rx_bit       <= '0;
            r_rx_shift     <= '0;
            r_rx_brk       <= 1'b0;
            r_rx_push      <= 1'b0;
            r_rx_frame_err <= 1'b0;
            r_rx_overrun   <= 1'b0;
        end else begin
            r_rx_state     <= w_rx_state_nx;
            r_rx_cnt       <= w_rx_cnt_nx;
            r_rx_bit       <= w_rx_bit_nx;
            r_rx_shift     <= w_rx_shift_nx;
            r_rx_brk       <= w_rx_brk_nx;
            r_rx_push      <= w_rx_push_nx;
            r_rx_frame_err <= w_rx_ferr_nx;
            r_rx_overrun   <= r_rx_push & w_rx_full & ~rx_ready;
        end
    end

`ifdef XBEE_UART_PARITY_EN
    // Parity bits for the frame in flight in each direction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_par <= 1'b0;
            r_rx_par <= 1'b0;
        end else begin
            r_tx_par <= w_tx_par_nx;
            r_rx_par <= w_rx_par_nx;
        end
    end
`endif

endmodule

// File: tb/tb_xbee_uart_fifo.sv
// Directed self-checking bench for xbee_uart_fifo at 10 clocks per bit, 4-deep FIFOs.
module tb_xbee_uart_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       txd;
    logic       rxd;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic [2:0] tx_level;
    logic [2:0] rx_level;

    logic       loopback;
    logic       rxd_drv;
    int         n_checks;
    int         n_errors;
    int         n_ovr;
    int         n_ferr;
    logic [7:0] got_q[$];
    logic [7:0] burst[5];
    int         q_base;
    int         ovr_base;
    int         ferr_base;

    assign rxd = loopback ? txd : rxd_drv;

    xbee_uart_fifo #(
        .CLKFREQ(1_000_000), .BAUD(100_000), .DATA_WIDTH(8), .TX_DEPTH(4), .RX_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .txd(txd), .rxd(rxd),
        .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err),
        .tx_level(tx_level), .rx_level(rx_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Receive-side observer: counts pulses and records every popped character.
    always @(negedge clk) begin
        #1;
        if (rx_overrun) n_ovr++;
        if (rx_frame_err) n_ferr++;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tx_write(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Called on the negedge where the start bit first shows; returns 100 clocks later.
    task automatic tx_expect_frame(input logic [7:0] d);
        logic [9:0] fr;
        int         b;
        fr = {1'b1, d, 1'b0};
        for (int c = 0; c < 100; c++) begin
            b = c / 10;
            check_eq("txd_frame", 32'(txd), 32'(fr[b[3:0]]));
            @(negedge clk);
        end
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic stop_bit);
        rxd_drv = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_drv = d[i];
            repeat (10) @(negedge clk);
        end
        rxd_drv = stop_bit;
        repeat (10) @(negedge clk);
        rxd_drv = 1'b1;
    endtask

    task automatic mark;
        q_base    = got_q.size();
        ovr_base  = n_ovr;
        ferr_base = n_ferr;
    endtask

    function automatic logic [31:0] got(input int idx);
        if (q_base + idx < got_q.size()) return 32'(got_q[q_base + idx]);
        else return 32'hDEAD;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_ovr    = 0;
        n_ferr   = 0;
        reset    = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        loopback = 1'b0;
        rxd_drv  = 1'b1;
        burst    = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7};
        repeat (3) @(negedge clk);
        check_eq("rst_txd", 32'(txd), 32'd1);
        check_eq("rst_tx_ready", 32'(tx_ready), 32'd1);
        check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_eq("rst_rx_data", 32'(rx_data), 32'd0);
        check_eq("rst_overrun", 32'(rx_overrun), 32'd0);
        check_eq("rst_frame_err", 32'(rx_frame_err), 32'd0);
        check_eq("rst_tx_level", 32'(tx_level), 32'd0);
        check_eq("rst_rx_level", 32'(rx_level), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single 0xA5 frame with 2-clock write-to-start latency.
        tx_write(8'hA5);
        check_eq("tx_latency_idle", 32'(txd), 32'd1);
        @(negedge clk);
        tx_expect_frame(8'hA5);
        check_eq("tx_after_frame", 32'(txd), 32'd1);
        check_eq("tx_level_drained", 32'(tx_level), 32'd0);

        // Burst of five: FIFO fills, sixth write ignored, frames contiguous.
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    tx_data  = burst[i];
                    tx_valid = 1'b1;
                    @(negedge clk);
                end
                check_eq("burst_tx_ready_full", 32'(tx_ready), 32'd0);
                check_eq("burst_tx_level_full", 32'(tx_level), 32'd4);
                tx_data = 8'h77;
                @(negedge clk);
                tx_valid = 1'b0;
                check_eq("burst_ignored_write", 32'(tx_level), 32'd4);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                for (int i = 0; i < 5; i++) tx_expect_frame(burst[i]);
            end
        join
        check_eq("burst_idle_txd", 32'(txd), 32'd1);
        check_eq("burst_tx_level_end", 32'(tx_level), 32'd0);

        // Loopback with the consumer always ready.
        loopback = 1'b1;
        rx_ready = 1'b1;
        mark();
        tx_write(8'h00);
        tx_write(8'hFF);
        tx_write(8'h3C);
        repeat (400) @(negedge clk);
        check_eq("lb_count", 32'(got_q.size() - q_base), 32'd3);
        check_eq("lb_data0", got(0), 32'h00);
        check_eq("lb_data1", got(1), 32'hFF);
        check_eq("lb_data2", got(2), 32'h3C);
        check_eq("lb_overrun", 32'(n_ovr - ovr_base), 32'd0);
        check_eq("lb_frame_err", 32'(n_ferr - ferr_base), 32'd0);

        // Loopback with the consumer stalled: fifth character overruns.
        rx_ready = 1'b0;
        mark();
        tx_write(8'h11);
        tx_write(8'h22);
        tx_write(8'h33);
        tx_write(8'h44);
        tx_write(8'h55);
        repeat (600) @(negedge clk);
        check_eq("ovr_rx_level", 32'(rx_level), 32'd4);
        check_eq("ovr_pulses", 32'(n_ovr - ovr_base), 32'd1);
        check_eq("ovr_rx_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        repeat (6) @(negedge clk);
        rx_ready = 1'b0;
        check_eq("ovr_pop_count", 32'(got_q.size() - q_base), 32'd4);
        check_eq("ovr_pop0", got(0), 32'h11);
        check_eq("ovr_pop1", got(1), 32'h22);
        check_eq("ovr_pop2", got(2), 32'h33);
        check_eq("ovr_pop3", got(3), 32'h44);
        check_eq("ovr_rx_level_end", 32'(rx_level), 32'd0);

        // Short low glitch on rxd must not start a character.
        loopback = 1'b0;
        rxd_drv  = 1'b1;
        repeat (5) @(negedge clk);
        mark();
        rxd_drv = 1'b0;
        repeat (3) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (200) @(negedge clk);
        check_eq("glitch_rx_level", 32'(rx_level), 32'd0);
        check_eq("glitch_frame_err", 32'(n_ferr - ferr_base), 32'd0);
        check_eq("glitch_overrun", 32'(n_ovr - ovr_base), 32'd0);

        // Low stop bit is a framing error; a following good frame still lands.
        mark();
        drive_rx(8'h5A, 1'b0);
        repeat (20) @(negedge clk);
        check_eq("ferr_pulses", 32'(n_ferr - ferr_base), 32'd1);
        check_eq("ferr_rx_level", 32'(rx_level), 32'd0);
        drive_rx(8'hC3, 1'b1);
        repeat (20) @(negedge clk);
        check_eq("good_rx_level", 32'(rx_level), 32'd1);
        check_eq("good_rx_data", 32'(rx_data), 32'hC3);
        check_eq("good_frame_err", 32'(n_ferr - ferr_base), 32'd1);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check_eq("good_drained", 32'(rx_level), 32'd0);

        // Reset during data bit 4 aborts the frame and flushes the queue.
        tx_write(8'h0F);
        tx_write(8'hF0);
        repeat (55) @(negedge clk);
        check_eq("pre_reset_txd", 32'(txd), 32'd0);
        check_eq("pre_reset_tx_level", 32'(tx_level), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_reset_txd", 32'(txd), 32'd1);
        check_eq("mid_reset_tx_level", 32'(tx_level), 32'd0);
        check_eq("mid_reset_rx_level", 32'(rx_level), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_reset_idle", 32'(txd), 32'd1);
        tx_write(8'h96);
        check_eq("post_reset_latency", 32'(txd), 32'd1);
        @(negedge clk);
        tx_expect_frame(8'h96);
        check_eq("post_reset_end_txd", 32'(txd), 32'd1);
        check_eq("post_reset_tx_level", 32'(tx_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
